// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART receiver.
// Optional parity support is enabled with UART_RX_PARITY_EN.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Whole clk cycles per line bit; the fractional part is truncated.
    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery and error-pulse interface between uart_rx and its consumer.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] data;
    logic                   valid;
    logic                   ready;
    logic                   frame_err;
    logic                   overrun;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err;

    modport master (output data, output valid, output frame_err, output overrun,
                    output parity_err, input ready);
    modport slave  (input data, input valid, input frame_err, input overrun,
                    input parity_err, output ready);
`else
    modport master (output data, output valid, output frame_err, output overrun,
                    input ready);
    modport slave  (input data, input valid, input frame_err, input overrun,
                    output ready);
`endif

endinterface

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// configurable reset value so an idle-high line does not look active out of reset.
module uart_rx_bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments keep the two stages as distinct flops;
    // blocking ones would collapse the chain into a single register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-entry valid/ready holding register,
// single-cycle framing/overrun pulses. Define UART_RX_PARITY_EN for even parity.
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_CLK_FREQ = 24_000_000,
    parameter int UART_BAUD     = 115_200
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     uart_rxd,
    uart_rx_if.master rx_if
);

    localparam int BIT_CYC  = cycles_per_bit(UART_CLK_FREQ, UART_BAUD);
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC);
    localparam int IDX_W    = $clog2(UART_DATA_W);

    if (BIT_CYC < 4) begin : g_bit_cyc_chk
        $error("uart_rx: BIT_CYC must be at least 4");
    end

    logic                   rx_s;
    rx_state_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic [UART_DATA_W-1:0] data_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   sample;
    logic                   byte_ok;

    uart_rx_bit_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (uart_rxd),
        .q_o   (rx_s)
    );

    assign sample = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    logic parity_bad_q;

    assign byte_ok          = !parity_bad_q;
    assign rx_if.parity_err = parity_err_q;
`else
    assign byte_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Consumption; a byte delivered in this same cycle overrides it below.
            if (valid_q && rx_if.ready) valid_q <= 1'b0;

            // NOTE: every state is listed with a default arm so an illegal
            // encoding recovers to IDLE instead of holding forever.
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= CNT_W'(HALF_CYC - 1);
                    end
                end
                START: begin
                    if (!sample) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!rx_s) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        cnt_q     <= CNT_W'(BIT_CYC - 1);
`ifdef UART_RX_PARITY_EN
                        parity_bad_q <= 1'b0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (!sample) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        shift_q   <= {rx_s, shift_q[UART_DATA_W-1:1]};
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                        cnt_q     <= CNT_W'(BIT_CYC - 1);
                        if (bit_idx_q == IDX_W'(UART_DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (!sample) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q      <= STOP;
                        cnt_q        <= CNT_W'(BIT_CYC - 1);
                        parity_bad_q <= (rx_s != ^shift_q);
                        parity_err_q <= (rx_s != ^shift_q);
                    end
                end
`endif
                STOP: begin
                    if (!sample) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (rx_s) begin
                        state_q <= IDLE;
                        if (byte_ok) begin
                            if (!valid_q || rx_if.ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_if.data      = data_q;
    assign rx_if.valid     = valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;

endmodule
